// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to the instruction cache and queues {pc, instr} for decode.
// Optional saturating perf counters are enabled by defining IFU_PERF_COUNTERS_EN.
module instr_fetch_unit #(
   parameter int unsigned            ADDR_WIDTH  = 32,
   parameter int unsigned            DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
   parameter int unsigned            QUEUE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  CPU_READ,
   output logic [ADDR_WIDTH-1:0] CPU_ADDRESS,
   input  logic [DATA_WIDTH-1:0] CPU_INSTR,
   input  logic                  CPU_BUSYWAIT,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  id_ready
`ifdef IFU_PERF_COUNTERS_EN
   ,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_stall
`endif
);

   localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StFetch, StSquash} state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   pc_q;
   logic [ADDR_WIDTH-1:0]   pending_pc_q;
   logic                    held_q;
   logic [PtrW-1:0]         wr_ptr_q;
   logic [PtrW-1:0]         rd_ptr_q;
   logic [CntW-1:0]         count_q;
   logic [DATA_WIDTH-1:0]   instr_mem_q [QUEUE_DEPTH];
   logic [ADDR_WIDTH-1:0]   pc_mem_q    [QUEUE_DEPTH];

   logic                    cpu_read;
   logic                    done;
   logic                    enq;
   logic                    deq;
   logic [ADDR_WIDTH-1:0]   redir_pc;

   // held_q keeps a stalled request alive even if the queue state would otherwise block it
   assign cpu_read = reset_n & ((state_q == StSquash) | held_q |
                                (count_q < CntW'(QUEUE_DEPTH)));
   assign done     = cpu_read & ~CPU_BUSYWAIT;
   assign enq      = (state_q == StFetch) & done & ~redirect_valid;
   assign deq      = (count_q != '0) & id_ready;
   assign redir_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

   assign CPU_READ    = cpu_read;
   assign CPU_ADDRESS = pc_q;
   assign if_valid    = (count_q != '0);
   assign if_instr    = instr_mem_q[rd_ptr_q];
   assign if_pc       = pc_mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         pending_pc_q <= '0;
         held_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         held_q <= cpu_read & CPU_BUSYWAIT;

         if (enq) begin
            instr_mem_q[wr_ptr_q] <= CPU_INSTR;
            pc_mem_q[wr_ptr_q]    <= pc_q;
         end

         unique case (state_q)
            StFetch: begin
               if (redirect_valid) begin
                  // A stalled request cannot be withdrawn, so park the target until it drains
                  if (cpu_read && CPU_BUSYWAIT) begin
                     pending_pc_q <= redir_pc;
                     state_q      <= StSquash;
                  end else begin
                     pc_q <= redir_pc;
                  end
               end else if (done) begin
                  pc_q <= pc_q + ADDR_WIDTH'(4);
               end
            end
            StSquash: begin
               if (done) begin
                  pc_q    <= redirect_valid ? redir_pc : pending_pc_q;
                  state_q <= StFetch;
               end else if (redirect_valid) begin
                  pending_pc_q <= redir_pc;
               end
            end
         endcase

         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(enq) - CntW'(deq);
         end
      end
   end

`ifdef IFU_PERF_COUNTERS_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (enq && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
         if (cpu_read && CPU_BUSYWAIT && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule
